// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and constants for the multi-port register file
// Purpose: default geometry, the all-zero data word and the enable polarities
//          used by regfile_mp and regfile_rd_port.
// Ports:   none (package).
package regfile_pkg;

   localparam int RF_DW   = 32;
   localparam int RF_AW   = 5;
   localparam int RF_NREG = 1 << RF_AW;

   localparam logic [RF_DW-1:0] ZeroWord = '0;

   // Active level of the per-port write (WB) and read (ID) enables.
   localparam logic WE_ACTIVE = 1'b1;
   localparam logic RE_ACTIVE = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with write bypass and busy lookup
// Purpose: selects stored data or same-cycle write data for one read address and
//          reports whether the addressed register is still awaiting its producer.
// Ports:   rst_i       reset, forces zero outputs
//          re_i        read enable
//          raddr_i     read address
//          we_i/waddr_i/wdata_i  packed write ports (port i at slice i)
//          reg_data_i  stored value of regs[raddr_i]
//          reg_busy_i  stored busy bit of regs[raddr_i]
//          rdata_o     read data
//          rbusy_o     busy flag for the addressed register
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int NW       = 1,
   parameter int ZERO_REG = 1
) (
   input  logic             rst_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   input  logic [NW-1:0]    we_i,
   input  logic [NW*AW-1:0] waddr_i,
   input  logic [NW*DW-1:0] wdata_i,
   input  logic [DW-1:0]    reg_data_i,
   input  logic             reg_busy_i,
   output logic [DW-1:0]    rdata_o,
   output logic             rbusy_o
);

   logic          hit;
   logic [DW-1:0] byp_data;

   // Ascending scan so the highest-numbered matching write port is the one kept.
   always_comb begin
      hit      = 1'b0;
      byp_data = DW'(ZeroWord);
      for (int i = 0; i < NW; i++) begin
         if (we_i[i] == WE_ACTIVE && waddr_i[i*AW +: AW] == raddr_i) begin
            hit      = 1'b1;
            byp_data = wdata_i[i*DW +: DW];
         end
      end
   end

   // A write in flight supplies the value now, so the register is not reported busy.
   always_comb begin
      rdata_o = DW'(ZeroWord);
      rbusy_o = 1'b0;
      if (rst_i || re_i != RE_ACTIVE || (ZERO_REG != 0 && raddr_i == '0)) begin
         rdata_o = DW'(ZeroWord);
         rbusy_o = 1'b0;
      end else if (hit) begin
         rdata_o = byp_data;
      end else begin
         rdata_o = reg_data_i;
         rbusy_o = reg_busy_i;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with integrated busy-bit scoreboard
// Purpose: NREG x DW storage with NW write ports (WB) and NR bypassing read ports (ID),
//          plus one busy bit per register set at issue and cleared at writeback.
// Ports:   clk, rst            clock and synchronous active-high reset
//          we/waddr/wdata      packed write ports
//          re/raddr            packed read ports
//          rdata/rbusy         combinational read data and busy flags
//          sb_set/sb_addr      mark destination register busy at issue
//          flush               clear every busy bit
//          busy_vec            registered busy bits
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int NREG     = RF_NREG,
   parameter int AW       = RF_AW,
   parameter int NR       = 2,
   parameter int NW       = 1,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NW-1:0]    we,
   input  logic [NW*AW-1:0] waddr,
   input  logic [NW*DW-1:0] wdata,
   input  logic [NR-1:0]    re,
   input  logic [NR*AW-1:0] raddr,
   output logic [NR*DW-1:0] rdata,
   output logic [NR-1:0]    rbusy,
   input  logic             sb_set,
   input  logic [AW-1:0]    sb_addr,
   input  logic             flush,
   output logic [NREG-1:0]  busy_vec
);

   logic [DW-1:0]   regs_q [NREG];
   logic [DW-1:0]   regs_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Ascending port order: the highest port writing an address lands last and wins.
   always_comb begin
      for (int k = 0; k < NREG; k++) begin
         regs_d[k] = regs_q[k];
      end
      for (int i = 0; i < NW; i++) begin
         if (we[i] == WE_ACTIVE && !(ZERO_REG != 0 && waddr[i*AW +: AW] == '0)) begin
            regs_d[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
         end
      end
   end

   // Writeback clears are applied first so a same-cycle issue to the same register
   // re-marks it busy: the newly issued instruction now owns that register.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (we[i] == WE_ACTIVE) begin
               busy_d[waddr[i*AW +: AW]] = 1'b0;
            end
         end
         if (sb_set && !(ZERO_REG != 0 && sb_addr == '0)) begin
            busy_d[sb_addr] = 1'b1;
         end
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) begin
            regs_q[k] <= DW'(ZeroWord);
         end
         busy_q <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            regs_q[k] <= regs_d[k];
         end
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   for (genvar j = 0; j < NR; j++) begin : g_rd
      regfile_rd_port #(
         .DW       (DW),
         .AW       (AW),
         .NW       (NW),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .rst_i      (rst),
         .re_i       (re[j]),
         .raddr_i    (raddr[j*AW +: AW]),
         .we_i       (we),
         .waddr_i    (waddr),
         .wdata_i    (wdata),
         .reg_data_i (regs_q[raddr[j*AW +: AW]]),
         .reg_busy_i (busy_q[raddr[j*AW +: AW]]),
         .rdata_o    (rdata[j*DW +: DW]),
         .rbusy_o    (rbusy[j])
      );
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file with an integrated register scoreboard. It is the successor to the current 2-read/1-write regfile. It serves a superscalar ID stage with NR read ports and a multi-issue WB stage with NW write ports. Each register carries a busy bit, set at issue and cleared at writeback, so ID can detect RAW hazards without a separate unit.

Parameters:
DW, 32, data width per register
NREG, 32, number of registers (power of 2)
AW, 5, address width, log2(NREG)
NR, 2, number of read ports
NW, 1, number of write ports
ZERO_REG, 1, 1: register 0 hardwired to zero and never busy

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
we  in  NW  per-port write enable (WB stage)
waddr  in  NW*AW  write addresses, port i at bits [i*AW +: AW]
wdata  in  NW*DW  write data, port i at bits [i*DW +: DW]
re  in  NR  per-port read enable (ID stage)
raddr  in  NR*AW  read addresses
rdata  out  NR*DW  read data, combinational
rbusy  out  NR  busy bit of addressed register, combinational
sb_set  in  1  mark register sb_addr busy (instruction issued)
sb_addr  in  AW  destination register being issued
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NREG  registered busy bits, debug/stall logic

Behaviour:
- Reset (rst=1 at posedge): all NREG registers cleared to 0 and all busy bits cleared, in the same cycle. While rst=1, rdata=0, rbusy=0, and busy_vec shows registered state (all 0 after the first reset edge). Writes and sb_set are ignored during reset.
- Write: at posedge, if we[i] is set, regs[waddr[i]] <= wdata[i].
  - If ZERO_REG=1, writes to address 0 are dropped.
  - If several ports write the same address in one cycle, the highest port index wins.
- Read port j (combinational, zero latency):
  - rst=1: rdata=0.
  - re[j]=0: rdata=0.
  - ZERO_REG=1 and raddr[j]=0: rdata=0.
  - Otherwise, if any port i has we[i]=1 and waddr[i]=raddr[j]: rdata is wdata of the highest such i (same-cycle bypass).
  - Otherwise rdata=regs[raddr[j]].
- rbusy[j]: 0 on reset, when re[j]=0, or when ZERO_REG=1 and raddr[j]=0.
  - If a write to raddr[j] is in flight this cycle, rbusy=0, because the bypassed value is valid.
  - Otherwise rbusy=busy[raddr[j]].
- Scoreboard update at posedge, priority high to low:
  1. rst: all busy bits = 0.
  2. flush: all busy bits = 0; sb_set ignored.
  3. sb_set: busy[sb_addr] <= 1. If sb_addr equals a same-cycle write address, set wins, because the newer producer owns the register.
  4. Each we[i]: busy[waddr[i]] <= 0.
- Registers are unaffected by flush.
- sb_set to address 0 is ignored when ZERO_REG=1.
- Reset mid-operation: any pending write and sb_set in the reset cycle are discarded.
- Data is unsigned, width DW; no arithmetic is performed. Out-of-range addresses cannot occur because NREG=2^AW.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW/AW/NREG;
  - the ZeroWord constant;
  - enable polarity constants for write/read enable, matching the existing defines.
- One natural sub-module, regfile_rd_port: a single read port with NW-way bypass priority mux, zero-register handling and rbusy generation, instantiated NR times via generate.
- The storage array and scoreboard stay in the top level.

Test Plan:
1. Reset clears: preload r5=0xDEADBEEF, r7 busy; assert rst 1 cycle -> read r5 gives 0x00000000, rbusy=0, busy_vec=0.
2. Write then read: we0=1, waddr0=3, wdata0=0x12345678; next cycle re0=1, raddr0=3 -> rdata0=0x12345678, and r0 reads 0 after attempting a write of 0xFFFFFFFF to r0.
3. Bypass and write collision (NW=2): same cycle port0 writes r9=0xAAAA0000 and port1 writes r9=0x0000BBBB, read raddr1=9 -> rdata1=0x0000BBBB combinationally; the following cycle regs[9]=0x0000BBBB.
4. Scoreboard lifecycle: sb_set r4 -> next cycle rbusy=1 for raddr=4. A write to r4 then gives rbusy=0 in the write cycle with bypassed data. After that edge, busy_vec[4]=0.
5. Set/clear collision: same cycle sb_set r6 and we0 to r6 -> after edge busy_vec[6]=1 and regs[6] updated.
6. Flush priority: r2 and r8 busy, flush=1 with sb_set r10 -> busy_vec=0 (r10 not set); register contents unchanged.
